// File: rtl/yc_router_inport.sv
// Router input port: flit FIFO with valid/ready handshake and XY route computed at enqueue.
// Optional YC_INPORT_STATS_EN adds saturating accepted-flit and head-stall counters.

package yc_noc_defs;
    typedef struct packed {
        logic [1:0]  ftype;
        logic [3:0]  src_x;
        logic [3:0]  src_y;
        logic [3:0]  dst_x;
        logic [3:0]  dst_y;
        logic [15:0] payload;
    } flit_t;

    function automatic logic [3:0] get_dst_x(input flit_t f);
        return f.dst_x;
    endfunction

    function automatic logic [3:0] get_dst_y(input flit_t f);
        return f.dst_y;
    endfunction
endpackage

module yc_router_inport
    import yc_noc_defs::*;
#(
    parameter int X_ID  = 0,
    parameter int Y_ID  = 0,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  flit_t                      in_flit,
    output logic                       in_ready,
    output logic                       out_valid,
    output flit_t                      out_flit,
    output logic [4:0]                 out_req,
    input  logic                       out_ready,
`ifdef YC_INPORT_STATS_EN
    output logic [15:0]                stat_flits,
    output logic [15:0]                stat_stalls,
`endif
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [3:0]  X4      = 4'(X_ID);
    localparam logic [3:0]  Y4      = 4'(Y_ID);

    typedef struct packed {
        logic [4:0] route;
        flit_t      flit;
    } entry_t;

    entry_t      mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full, empty, push, pop;
    logic [4:0]  route;
    logic [3:0]  dx, dy;
    entry_t      head;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // in_ready ignores out_ready on purpose: a full FIFO never accepts, even while popping.
    assign in_ready  = rst_n && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = wr_ptr_q - rd_ptr_q;

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign out_flit  = head.flit;
    assign out_req   = out_valid ? head.route : 5'b0;

    assign dx = get_dst_x(in_flit);
    assign dy = get_dst_y(in_flit);

    // Dimension-ordered: resolve X first, then Y; bits are {L,W,S,E,N}.
    always_comb begin
        route = 5'b0;
        if (dx > X4)      route = 5'b00010;
        else if (dx < X4) route = 5'b01000;
        else if (dy > Y4) route = 5'b00100;
        else if (dy < Y4) route = 5'b00001;
        else              route = 5'b10000;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{route: route, flit: in_flit};
    end

`ifdef YC_INPORT_STATS_EN
    logic [15:0] stat_flits_q, stat_flits_d;
    logic [15:0] stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_flits_d  = stat_flits_q;
        stat_stalls_d = stat_stalls_q;
        if (push && stat_flits_q != 16'hFFFF)
            stat_flits_d = stat_flits_q + 16'd1;
        if (out_valid && !out_ready && stat_stalls_q != 16'hFFFF)
            stat_stalls_d = stat_stalls_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_flits_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_flits_q  <= stat_flits_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_flits  = stat_flits_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_yc_router_inport.sv
// Bench for yc_router_inport (X_ID=1, Y_ID=1, DEPTH=4): route table plus scoreboarded FIFO sequences.
// Stat counter checks are included when YC_INPORT_STATS_EN is defined.

module tb_yc_router_inport;
    import yc_noc_defs::*;

    localparam int XI = 1;
    localparam int YI = 1;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    flit_t       in_flit;
    logic        in_ready;
    logic        out_valid;
    flit_t       out_flit;
    logic [4:0]  out_req;
    logic        out_ready;
    logic [2:0]  occupancy;
`ifdef YC_INPORT_STATS_EN
    logic [15:0] stat_flits;
    logic [15:0] stat_stalls;
`endif

    yc_router_inport #(.X_ID(XI), .Y_ID(YI), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
        .out_valid(out_valid), .out_flit(out_flit), .out_req(out_req), .out_ready(out_ready),
`ifdef YC_INPORT_STATS_EN
        .stat_flits(stat_flits), .stat_stalls(stat_stalls),
`endif
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] seq = 16'h0100;

    typedef struct {
        logic [15:0] payload;
        logic [4:0]  req;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] dx;
        logic [3:0] dy;
        logic [4:0] req;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_route(input logic [3:0] x, input logic [3:0] y);
        if (int'(x) > XI) return 5'b00010;
        if (int'(x) < XI) return 5'b01000;
        if (int'(y) > YI) return 5'b00100;
        if (int'(y) < YI) return 5'b00001;
        return 5'b10000;
    endfunction

    function automatic flit_t make_flit(input logic [3:0] x, input logic [3:0] y, input logic [15:0] p);
        flit_t f;
        f = '0;
        f.dst_x = x;
        f.dst_y = y;
        f.payload = p;
        return f;
    endfunction

    // Scoreboard: sample handshakes mid-cycle; they commit at the following posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got payload 0x%0h, expected nothing at %0t", out_flit.payload, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_payload", 32'(out_flit.payload), 32'(e.payload));
                    check("sb_req", 32'(out_req), 32'(e.req));
                end
            end
            if (in_valid && in_ready)
                sb.push_back('{payload: in_flit.payload, req: model_route(in_flit.dst_x, in_flit.dst_y)});
        end
    end

    // One clock; advance the payload counter when the current flit was accepted.
    task automatic step();
        logic acc;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            seq = seq + 16'd1;
            in_flit = make_flit(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), seq);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && out_valid; i++) step();
        check("drain_empty", 32'(out_valid), 32'd0);
    endtask

    initial begin
        tbl[0] = '{4'd2,  4'd1,  5'b00010};
        tbl[1] = '{4'd0,  4'd1,  5'b01000};
        tbl[2] = '{4'd1,  4'd2,  5'b00100};
        tbl[3] = '{4'd1,  4'd0,  5'b00001};
        tbl[4] = '{4'd1,  4'd1,  5'b10000};
        tbl[5] = '{4'd15, 4'd0,  5'b00010};
        tbl[6] = '{4'd1,  4'd15, 5'b00100};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_flit = make_flit(4'd0, 4'd0, seq);
        #1;
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_out_req", 32'(out_req), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_high", 32'(in_ready), 32'd1);

        // Route decode: each flit visible exactly one cycle after its push.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_flit = make_flit(tbl[i].dx, tbl[i].dy, seq);
            in_valid = 1'b1;
            check("route_not_fallthrough", 32'(out_valid), 32'd0);
            step();
            in_valid = 1'b0;
            check("route_valid", 32'(out_valid), 32'd1);
            check("route_req", 32'(out_req), 32'(tbl[i].req));
            check("route_payload", 32'(out_flit.payload), 32'(seq - 16'd1));
            step();
            check("route_popped", 32'(occupancy), 32'd0);
        end

        // Fill with out_ready low, then release.
        begin
            logic [15:0] first;
            first = seq;
            in_flit = make_flit(4'd3, 4'd3, seq);
            out_ready = 1'b0; in_valid = 1'b1;
            repeat (6) step();
            check("fill_in_ready", 32'(in_ready), 32'd0);
            check("fill_occupancy", 32'(occupancy), 32'd4);
            check("fill_head_stable", 32'(out_flit.payload), 32'(first));
            in_valid = 1'b0; out_ready = 1'b1;
            step();
            check("fill_ready_after_pop", 32'(in_ready), 32'd1);
            check("fill_occ_after_pop", 32'(occupancy), 32'd3);
            drain();
        end

        // Steady push/pop at occupancy 2; 12 pushes wrap the pointers.
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) step();
        check("pp_occ_start", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("pp_occ_steady", 32'(occupancy), 32'd2);
        end
        drain();

        // Full and popping in the same cycle: no push that cycle.
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (4) step();
        check("fp_full", 32'(occupancy), 32'd4);
        out_ready = 1'b1;
        check("fp_in_ready_low", 32'(in_ready), 32'd0);
        step();
        check("fp_in_ready_high", 32'(in_ready), 32'd1);
        check("fp_occupancy", 32'(occupancy), 32'd3);
        drain();

        // Reset mid-stream discards buffered flits.
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (3) step();
        check("mr_occ3", 32'(occupancy), 32'd3);
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_occupancy", 32'(occupancy), 32'd0);
        check("mr_out_req", 32'(out_req), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        begin
            logic [15:0] fresh;
            fresh = seq;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check("mr_first_after", 32'(out_flit.payload), 32'(fresh));
            drain();
        end

`ifdef YC_INPORT_STATS_EN
        rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        check("st_flits_rst", 32'(stat_flits), 32'd0);
        check("st_stalls_rst", 32'(stat_stalls), 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        out_ready = 1'b1; in_valid = 1'b1;
        repeat (19) step();
        drain();
        check("st_flits", 32'(stat_flits), 32'd20);
        check("st_stalls", 32'(stat_stalls), 32'd7);
        out_ready = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (65540) step();
        check("st_stalls_sat", 32'(stat_stalls), 32'hFFFF);
        check("st_flits_21", 32'(stat_flits), 32'd21);
        drain();
`endif

        step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
